// File: rtl/mod_counter_sched.sv
// rtl/mod_counter_sched.sv - round-robin scheduler sharing one mod-N counter among R requesters
module mod_counter_sched #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [R-1:0]     req,
    input  logic [R*N-1:0]   req_len,
    output logic [R-1:0]     gnt,
    output logic [N-1:0]     q,
    output logic [R-1:0]     done,
    output logic             busy
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [N-1:0]  len;

    logic          found;
    logic [PW-1:0] win;
    logic [N-1:0]  win_len;
    logic [PW-1:0] owner_next;
    logic [R-1:0]  owner_onehot;
    logic [R-1:0]  win_onehot;

    // Round-robin search starting at ptr; scanning downward lets the lowest offset win.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int k = R - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % R;
            if (req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_len      = req_len[int'(win)*N +: N];
        owner_next   = (owner == PW'(R - 1)) ? '0 : owner + 1'b1;
        owner_onehot = {{(R-1){1'b0}}, 1'b1} << owner;
        win_onehot   = {{(R-1){1'b0}}, 1'b1} << win;
    end

    // Scheduler FSM with registered outputs; a zero length is run as a length of one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            q     <= '0;
            done  <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            owner <= '0;
            len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (found) begin
                        state <= RUN;
                        owner <= win;
                        gnt   <= win_onehot;
                        q     <= '0;
                        busy  <= 1'b1;
                        len   <= (win_len == '0) ? N'(1) : win_len;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        state <= IDLE;
                        gnt   <= '0;
                        q     <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner_next;
                    end else if (q == len - 1'b1) begin
                        state <= DONE;
                        gnt   <= '0;
                        q     <= '0;
                        busy  <= 1'b0;
                        done  <= owner_onehot;
                        ptr   <= owner_next;
                    end else begin
                        q <= q + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    q     <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_counter_sched.sv
// tb/tb_mod_counter_sched.sv - scoreboard bench for mod_counter_sched
module tb_mod_counter_sched;
    localparam int N = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [R-1:0]   req = '0;
    logic [R*N-1:0] req_len = '0;
    logic [R-1:0]   gnt;
    logic [N-1:0]   q;
    logic [R-1:0]   done;
    logic           busy;

    mod_counter_sched #(.N(N), .R(R)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .gnt(gnt), .q(q), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [R-1:0] gnt;
        logic [N-1:0] q;
        logic [R-1:0] done;
        logic         busy;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   gl_idx[$];
    int   gl_cyc[$];

    // Reference model: a run is (owner, length, position); a finished run leaves one quiet cycle.
    bit   m_active = 0, m_cool = 0;
    int   m_owner = 0, m_len = 1, m_pos = 0, m_ptr = 0, m_last = 0;
    int   mi;
    exp_t me;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_cool = 0; m_ptr = 0;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_active) begin
            if (!req[m_owner]) begin
                m_active = 0; m_ptr = (m_owner + 1) % R;
            end else if (m_pos == m_len - 1) begin
                m_active = 0; m_cool = 1; m_last = m_owner; m_ptr = (m_owner + 1) % R;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            for (int k = 0; k < R; k++) begin
                mi = (m_ptr + k) % R;
                if (req[mi]) begin
                    m_active = 1; m_owner = mi; m_pos = 0;
                    m_len = int'(req_len[mi*N +: N]);
                    if (m_len == 0) m_len = 1;
                    break;
                end
            end
        end
        me.gnt  = m_active ? R'(1 << m_owner) : '0;
        me.q    = m_active ? N'(m_pos) : '0;
        me.done = m_cool ? R'(1 << m_last) : '0;
        me.busy = m_active;
        expq.push_back(me);
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    exp_t        got;
    exp_t        ex;
    logic [R-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            ex  = expq.pop_front();
            got = {gnt, q, done, busy};
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL outputs cycle %0d: got gnt=%b q=%0d done=%b busy=%b, expected gnt=%b q=%0d done=%b busy=%b",
                         cyc, gnt, q, done, busy, ex.gnt, ex.q, ex.done, ex.busy);
            end
            checks++;
            if ($countones(gnt) > 1 || $countones(done) > 1 || (gnt != 0 && done != 0)) begin
                errors++;
                $display("FAIL onehot cycle %0d: gnt=%b done=%b", cyc, gnt, done);
            end
            if (gnt != 0 && prev_gnt == 0) begin
                for (int i = 0; i < R; i++) if (gnt[i]) gl_idx.push_back(i);
                gl_cyc.push_back(cyc);
            end
            prev_gnt = gnt;
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_log();
        gl_idx.delete();
        gl_cyc.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1; step(1); reset = 1'b0;
    endtask

    int t;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset held two cycles with every requester asking, len=3 everywhere.
        req = 4'b1111;
        for (int i = 0; i < R; i++) req_len[i*N +: N] = 8'd3;
        step(2);
        clear_log();
        reset = 1'b0;
        t = 0;
        while (gl_idx.size() < 5 && t < 60) begin step(1); t++; end
        chk("five_grants_seen", gl_idx.size() >= 5 ? 1 : 0, 1);
        if (gl_idx.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr_order[%0d]", i), gl_idx[i], exp_order[i]);
            for (int i = 1; i < 5; i++) chk($sformatf("rr_gap[%0d]", i), gl_cyc[i] - gl_cyc[i-1], 5);
        end

        // Single requester, len=8, held across one completion.
        req = '0; pulse_reset();
        req_len[0 +: N] = 8'd8; req = 4'b0001;
        clear_log();
        step(12);
        chk("len8_first_grant", gl_idx.size() > 0 ? gl_idx[0] : -1, 0);
        step(4); req = '0; step(3);

        // Length 0 is treated as 1, then length 1 proper.
        req_len[N +: N] = 8'd0; req = 4'b0010; step(6);
        req_len[N +: N] = 8'd1; step(6);
        req = '0; step(3);

        // Abort requester 1 at q=2; requester 2 is served next.
        pulse_reset();
        req_len[N +: N] = 8'd6; req_len[2*N +: N] = 8'd4; req = 4'b0110;
        t = 0;
        while (!(gnt == 4'b0010 && q == 8'd2) && t < 20) begin step(1); t++; end
        chk("abort_point_reached", t < 20 ? 1 : 0, 1);
        req[1] = 1'b0;
        clear_log();
        step(4);
        chk("after_abort_grant", gl_idx.size() > 0 ? gl_idx[0] : -1, 2);
        req = '0; step(8);

        // Largest supported length.
        req_len[3*N +: N] = 8'd255; req = 4'b1000;
        step(262);
        req = '0; step(2);

        // Reset mid-run clears the pointer.
        pulse_reset();
        req_len[2*N +: N] = 8'd10; req = 4'b0100;
        t = 0;
        while (!(gnt == 4'b0100 && q == 8'd5) && t < 20) begin step(1); t++; end
        chk("reset_point_reached", t < 20 ? 1 : 0, 1);
        reset = 1'b1; req = 4'b1111;
        for (int i = 0; i < R; i++) req_len[i*N +: N] = 8'd2;
        step(1);
        reset = 1'b0;
        clear_log();
        step(3);
        chk("grant_after_reset", gl_idx.size() > 0 ? gl_idx[0] : -1, 0);

        // Randomized traffic with aborts, length changes during runs, and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step(1);
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < R; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_len[i*N +: N] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                                       : 8'($urandom_range(0, 5));
                    end
                end else begin
                    if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
                    if ($urandom_range(0, 9) == 0) req_len[i*N +: N] = 8'($urandom_range(0, 7));
                end
            end
        end
        reset = 1'b0; req = '0;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
